// File: rtl/pipeline_sequencer_pkg.sv
// Shared definitions for the pipeline sequencer and its hazard unit.
// Holds the sequencer state encodings and the MIPS opcode constants. The control
// decoder uses the same opcode constants.
package pipeline_sequencer_pkg;

  localparam int unsigned NB_OPCODE_DEF   = 6;
  localparam int unsigned NB_REG_ADDR_DEF = 5;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  // Codes 6 and 7 are unused; the FSM sends them back to StIdle.
  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StRun      = 3'd1,
    StStepWait = 3'd2,
    StStepExec = 3'd3,
    StDrain    = 3'd4,
    StHalted   = 3'd5
  } state_e;

endpackage

// File: rtl/pipeline_sequencer_hazard_detect.sv
// hazard_detect: combinational load-use hazard compare.
// Ports:
//   i_idex_mem_read  MemRead of the instruction in ID/EX
//   i_idex_rt        destination rt of the load in ID/EX
//   i_ifid_rs        rs of the instruction in IF/ID
//   i_ifid_rt        rt of the instruction in IF/ID
//   o_stall          1 = the IF/ID instruction needs the loaded value next cycle
module hazard_detect
  import pipeline_sequencer_pkg::*;
#(
  parameter int unsigned NB_REG_ADDR = NB_REG_ADDR_DEF
) (
  input  logic                   i_idex_mem_read,
  input  logic [NB_REG_ADDR-1:0] i_idex_rt,
  input  logic [NB_REG_ADDR-1:0] i_ifid_rs,
  input  logic [NB_REG_ADDR-1:0] i_ifid_rt,
  output logic                   o_stall
);

  logic w_dest_nonzero;
  logic w_match;

  // A load into $zero never produces a value worth waiting for.
  assign w_dest_nonzero = (i_idex_rt != '0);
  assign w_match        = (i_idex_rt == i_ifid_rs) || (i_idex_rt == i_ifid_rt);
  assign o_stall        = i_idex_mem_read && w_dest_nonzero && w_match;

endmodule

// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: run/step/halt sequencer and hazard controller for the
// 5-stage MIPS pipeline.
// Ports:
//   i_clk, i_rst               clock, synchronous active-high reset
//   i_start, i_mode            leave IDLE; mode 0 = continuous, 1 = single-step
//   i_step                     advance one cycle from STEP_WAIT
//   i_opcode, i_ifid_rs/rt     fields of the instruction in IF/ID
//   i_idex_mem_read, i_idex_rt load information of the instruction in ID/EX
//   i_branch_taken, i_jump     control transfer resolved this cycle
//   o_pc_write, o_ifid_write   PC / IF/ID load enables
//   o_pipe_enable              load enable for ID/EX, EX/MEM, MEM/WB
//   o_ctrl_bubble              zero the control buses into ID/EX
//   o_ifid_flush               IF/ID loads a NOP
//   o_halted, o_state          registered status
//   o_cycle_count              saturating count of cycles with o_pipe_enable=1
module pipeline_sequencer
  import pipeline_sequencer_pkg::*;
#(
  parameter int unsigned          NB_OPCODE    = NB_OPCODE_DEF,
  parameter int unsigned          NB_REG_ADDR  = NB_REG_ADDR_DEF,
  parameter int unsigned          NB_CYCLE_CNT = 32,
  parameter logic [NB_OPCODE-1:0] HALT_OPCODE  = OP_HALT,
  parameter int unsigned          DRAIN_CYCLES = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic                    i_mode,
  input  logic                    i_step,
  input  logic [NB_OPCODE-1:0]    i_opcode,
  input  logic [NB_REG_ADDR-1:0]  i_ifid_rs,
  input  logic [NB_REG_ADDR-1:0]  i_ifid_rt,
  input  logic                    i_idex_mem_read,
  input  logic [NB_REG_ADDR-1:0]  i_idex_rt,
  input  logic                    i_branch_taken,
  input  logic                    i_jump,
  output logic                    o_pc_write,
  output logic                    o_ifid_write,
  output logic                    o_pipe_enable,
  output logic                    o_ctrl_bubble,
  output logic                    o_ifid_flush,
  output logic                    o_halted,
  output logic [2:0]              o_state,
  output logic [NB_CYCLE_CNT-1:0] o_cycle_count
);

  localparam int unsigned NB_DRAIN = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [NB_DRAIN-1:0] DRAIN_LOAD = NB_DRAIN'(DRAIN_CYCLES - 1);

  state_e                  r_state;
  state_e                  w_next_state;
  logic [NB_DRAIN-1:0]     r_drain_cnt;
  logic [NB_CYCLE_CNT-1:0] r_cycle_count;
  logic                    r_halted;
  logic                    w_drain_load;
  logic                    w_stall;
  logic                    w_flush_req;
  logic                    w_halt_req;

  hazard_detect #(
    .NB_REG_ADDR (NB_REG_ADDR)
  ) u_hazard_detect (
    .i_idex_mem_read (i_idex_mem_read),
    .i_idex_rt       (i_idex_rt),
    .i_ifid_rs       (i_ifid_rs),
    .i_ifid_rt       (i_ifid_rt),
    .o_stall         (w_stall)
  );

  assign w_flush_req = i_branch_taken || i_jump;
  assign w_halt_req  = (i_opcode == HALT_OPCODE);

  // Control outputs and next state. Flush beats load-use beats halt: a HALT
  // fetched down a mispredicted path must not stop the machine.
  always_comb begin
    o_pc_write    = 1'b0;
    o_ifid_write  = 1'b0;
    o_pipe_enable = 1'b0;
    o_ctrl_bubble = 1'b0;
    o_ifid_flush  = 1'b0;
    w_drain_load  = 1'b0;
    w_next_state  = r_state;
    case (r_state)
      StIdle: begin
        if (i_start) begin
          w_next_state = i_mode ? StStepWait : StRun;
        end
      end
      StRun, StStepExec: begin
        o_pc_write    = 1'b1;
        o_ifid_write  = 1'b1;
        o_pipe_enable = 1'b1;
        // A single step is consumed whatever happens in it.
        if (r_state == StStepExec) begin
          w_next_state = StStepWait;
        end
        if (w_flush_req) begin
          o_ifid_flush  = 1'b1;
          o_ctrl_bubble = 1'b1;
        end else if (w_stall) begin
          o_pc_write    = 1'b0;
          o_ifid_write  = 1'b0;
          o_ctrl_bubble = 1'b1;
        end else if (w_halt_req) begin
          o_pc_write    = 1'b0;
          o_ifid_write  = 1'b0;
          o_ctrl_bubble = 1'b1;
          w_drain_load  = 1'b1;
          w_next_state  = StDrain;
        end
      end
      StStepWait: begin
        if (i_step) begin
          w_next_state = StStepExec;
        end
      end
      StDrain: begin
        o_pipe_enable = 1'b1;
        o_ctrl_bubble = 1'b1;
        if (r_drain_cnt == '0) begin
          w_next_state = StHalted;
        end
      end
      StHalted: begin
        w_next_state = StHalted;
      end
      default: begin
        w_next_state = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= StIdle;
      r_drain_cnt   <= '0;
      r_cycle_count <= '0;
      r_halted      <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_halted <= (w_next_state == StHalted);
      if (w_drain_load) begin
        r_drain_cnt <= DRAIN_LOAD;
      end else if ((r_state == StDrain) && (r_drain_cnt != '0)) begin
        r_drain_cnt <= r_drain_cnt - 1'b1;
      end
      if (o_pipe_enable && (r_cycle_count != '1)) begin
        r_cycle_count <= r_cycle_count + 1'b1;
      end
    end
  end

  assign o_state       = r_state;
  assign o_halted      = r_halted;
  assign o_cycle_count = r_cycle_count;

endmodule

// File: tb/tb_pipeline_sequencer.sv
module tb_pipeline_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        mode;
  logic        step;
  logic [5:0]  opcode;
  logic [4:0]  ifid_rs;
  logic [4:0]  ifid_rt;
  logic        idex_mem_read;
  logic [4:0]  idex_rt;
  logic        branch_taken;
  logic        jump;

  logic        pc_write, ifid_write, pipe_enable, ctrl_bubble, ifid_flush, halted;
  logic [2:0]  state;
  logic [31:0] cycle_count;

  logic        s_pc_write, s_ifid_write, s_pipe_enable, s_ctrl_bubble, s_ifid_flush, s_halted;
  logic [2:0]  s_state;
  logic [3:0]  s_cycle_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipeline_sequencer dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_start         (start),
    .i_mode          (mode),
    .i_step          (step),
    .i_opcode        (opcode),
    .i_ifid_rs       (ifid_rs),
    .i_ifid_rt       (ifid_rt),
    .i_idex_mem_read (idex_mem_read),
    .i_idex_rt       (idex_rt),
    .i_branch_taken  (branch_taken),
    .i_jump          (jump),
    .o_pc_write      (pc_write),
    .o_ifid_write    (ifid_write),
    .o_pipe_enable   (pipe_enable),
    .o_ctrl_bubble   (ctrl_bubble),
    .o_ifid_flush    (ifid_flush),
    .o_halted        (halted),
    .o_state         (state),
    .o_cycle_count   (cycle_count)
  );

  // Narrow counter copy sharing the same stimulus, for saturation.
  pipeline_sequencer #(
    .NB_CYCLE_CNT (4)
  ) dut_sat (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_start         (start),
    .i_mode          (mode),
    .i_step          (step),
    .i_opcode        (opcode),
    .i_ifid_rs       (ifid_rs),
    .i_ifid_rt       (ifid_rt),
    .i_idex_mem_read (idex_mem_read),
    .i_idex_rt       (idex_rt),
    .i_branch_taken  (branch_taken),
    .i_jump          (jump),
    .o_pc_write      (s_pc_write),
    .o_ifid_write    (s_ifid_write),
    .o_pipe_enable   (s_pipe_enable),
    .o_ctrl_bubble   (s_ctrl_bubble),
    .o_ifid_flush    (s_ifid_flush),
    .o_halted        (s_halted),
    .o_state         (s_state),
    .o_cycle_count   (s_cycle_count)
  );

  // {pc_write, ifid_write, pipe_enable, ctrl_bubble, ifid_flush}
  function automatic logic [4:0] ctrl_vec();
    return {pc_write, ifid_write, pipe_enable, ctrl_bubble, ifid_flush};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    start = 0; mode = 0; step = 0; opcode = 6'd0;
    ifid_rs = 5'd0; ifid_rt = 5'd0; idex_mem_read = 0; idex_rt = 5'd0;
    branch_taken = 0; jump = 0;
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    tick(); tick();
    rst = 0;
    #1;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_count", cycle_count, 32'd0);
    chk("reset_halted", 32'(halted), 32'd0);
    chk("idle_ctrl", 32'(ctrl_vec()), 32'b00000);

    // i_step alone is ignored in IDLE
    step = 1;
    tick();
    step = 0;
    chk("idle_step_ignored", 32'(state), 32'd0);

    // Continuous run
    start = 1; mode = 0;
    tick();
    start = 0;
    #1;
    chk("run_state", 32'(state), 32'd1);
    chk("run_count0", cycle_count, 32'd0);
    chk("run_ctrl", 32'(ctrl_vec()), 32'b11100);
    tick();
    chk("run_count1", cycle_count, 32'd1);

    // Load-use on rs
    idex_mem_read = 1; idex_rt = 5'd8; ifid_rs = 5'd8;
    #1;
    chk("loaduse_ctrl", 32'(ctrl_vec()), 32'b00110);
    tick();
    chk("loaduse_state", 32'(state), 32'd1);
    chk("loaduse_count", cycle_count, 32'd2);

    // Load into $zero: no stall
    idex_rt = 5'd0; ifid_rs = 5'd0;
    #1;
    chk("zero_rt_ctrl", 32'(ctrl_vec()), 32'b11100);
    tick();
    idex_mem_read = 0;

    // HALT on the wrong path: flush wins
    opcode = 6'b111111; branch_taken = 1;
    #1;
    chk("flush_halt_ctrl", 32'(ctrl_vec()), 32'b11111);
    tick();
    chk("flush_halt_state", 32'(state), 32'd1);
    opcode = 6'd0; branch_taken = 0;

    // Load-use with jump: flush wins
    idex_mem_read = 1; idex_rt = 5'd8; ifid_rt = 5'd8; jump = 1;
    #1;
    chk("flush_loaduse_ctrl", 32'(ctrl_vec()), 32'b11111);
    tick();
    chk("flush_count", cycle_count, 32'd5);
    idex_mem_read = 0; idex_rt = 5'd0; ifid_rt = 5'd0; jump = 0;

    // HALT: detect cycle + 4 drain cycles
    opcode = 6'b111111;
    #1;
    chk("halt_ctrl", 32'(ctrl_vec()), 32'b00110);
    tick();
    opcode = 6'd0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("drain_state%0d", i), 32'(state), 32'd4);
      chk($sformatf("drain_ctrl%0d", i), 32'(ctrl_vec()), 32'b00110);
      tick();
    end
    chk("halted_state", 32'(state), 32'd5);
    chk("halted_flag", 32'(halted), 32'd1);
    chk("halted_count", cycle_count, 32'd10);
    chk("halted_ctrl", 32'(ctrl_vec()), 32'b00000);
    start = 1;
    tick();
    start = 0;
    chk("halted_start_ignored", 32'(state), 32'd5);

    // Single-step mode
    rst = 1;
    tick();
    rst = 0;
    chk("rst_from_halted", 32'(halted), 32'd0);
    start = 1; mode = 1; step = 1;
    tick();
    start = 0; mode = 0; step = 0;
    #1;
    chk("stepwait_state", 32'(state), 32'd2);
    chk("stepwait_ctrl", 32'(ctrl_vec()), 32'b00000);
    for (int i = 0; i < 3; i++) begin
      step = 1;
      tick();
      step = 0;
      #1;
      chk($sformatf("stepexec_ctrl%0d", i), 32'(ctrl_vec()), 32'b11100);
      tick();
    end
    chk("step3_count", cycle_count, 32'd3);
    chk("step3_state", 32'(state), 32'd2);
    step = 1;
    repeat (4) tick();
    step = 0;
    chk("held_step_count", cycle_count, 32'd5);
    chk("held_step_state", 32'(state), 32'd2);

    // Halt via a step, reset mid-drain
    opcode = 6'b111111; step = 1;
    tick();
    step = 0;
    #1;
    chk("step_halt_ctrl", 32'(ctrl_vec()), 32'b00110);
    tick();
    opcode = 6'd0;
    chk("step_drain_state", 32'(state), 32'd4);
    tick();
    rst = 1;
    tick();
    rst = 0;
    chk("rst_drain_state", 32'(state), 32'd0);
    chk("rst_drain_count", cycle_count, 32'd0);
    chk("rst_drain_halted", 32'(halted), 32'd0);

    // Saturation on the 4-bit counter
    start = 1;
    tick();
    start = 0;
    repeat (15) tick();
    chk("sat_count15", 32'(s_cycle_count), 32'd15);
    repeat (5) tick();
    chk("sat_hold", 32'(s_cycle_count), 32'd15);
    chk("wide_count20", cycle_count, 32'd20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
